// File: rtl/img_template_match.sv
// img_template_match
//   Streaming template matcher. Each valid camera pixel is mapped through a
//   window offset and a power-of-two downscale onto a cell of a loadable
//   template RAM. The matching template value is presented two cycles after
//   the pixel. Over one frame a saturating sum of absolute differences
//   between pixel and template is accumulated. The score and a threshold
//   match flag are reported once the frame ends.
//
// Ports
//   iCLK, iRST_N            clock, synchronous active-low reset
//   iDVAL, iX, iY, iPIX     pixel stream (valid, coordinates, value)
//   iFRAME_START/END        one-cycle frame delimiters
//   iTHRESH                 match threshold, sampled at report time
//   iWR_EN/ADDR/DATA        template write port, address is {ty,tx}
//   oVAL, oVAL_VALID        template value for the pixel and its qualifier
//   oIN_WIN                 the pixel fell inside the template window
//   oSCORE, oSCORE_VALID    last reported SAD and its one-cycle strobe
//   oMATCH                  oSCORE <= iTHRESH at report time
//   oBUSY                   a frame is being accumulated or drained
module img_template_match #(
    parameter int COORD_W    = 13,
    parameter int PIX_W      = 10,
    parameter int TPL_W_LOG2 = 4,
    parameter int TPL_H_LOG2 = 4,
    parameter int SHIFT      = 4,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int SCORE_W    = 24
) (
    input  logic                             iCLK,
    input  logic                             iRST_N,
    input  logic                             iDVAL,
    input  logic [COORD_W-1:0]               iX,
    input  logic [COORD_W-1:0]               iY,
    input  logic [PIX_W-1:0]                 iPIX,
    input  logic                             iFRAME_START,
    input  logic                             iFRAME_END,
    input  logic [SCORE_W-1:0]               iTHRESH,
    input  logic                             iWR_EN,
    input  logic [TPL_W_LOG2+TPL_H_LOG2-1:0] iWR_ADDR,
    input  logic [PIX_W-1:0]                 iWR_DATA,
    output logic [PIX_W-1:0]                 oVAL,
    output logic                             oVAL_VALID,
    output logic                             oIN_WIN,
    output logic [SCORE_W-1:0]               oSCORE,
    output logic                             oSCORE_VALID,
    output logic                             oMATCH,
    output logic                             oBUSY
);

    localparam int ADDR_W = TPL_W_LOG2 + TPL_H_LOG2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SUM_W  = ((SCORE_W > PIX_W) ? SCORE_W : PIX_W) + 1;

    localparam logic [COORD_W-1:0] X0_C    = COORD_W'(X0);
    localparam logic [COORD_W-1:0] Y0_C    = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] W_CELLS = COORD_W'(1 << TPL_W_LOG2);
    localparam logic [COORD_W-1:0] H_CELLS = COORD_W'(1 << TPL_H_LOG2);
    localparam logic [SUM_W-1:0]   ACC_MAX = SUM_W'({SCORE_W{1'b1}});

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

    state_t state, stateNext;
    logic [1:0] drainCnt;
    logic       accClear;
    logic       tag0;

    // Stage 0: window test and RAM address
    logic [COORD_W-1:0] dx, dy, cellX, cellY;
    logic               inWin0;
    logic [ADDR_W-1:0]  rdAddr;

    always_comb begin
        dx     = iX - X0_C;
        dy     = iY - Y0_C;
        cellX  = dx >> SHIFT;
        cellY  = dy >> SHIFT;
        inWin0 = iDVAL && (iX >= X0_C) && (iY >= Y0_C) &&
                 (cellX < W_CELLS) && (cellY < H_CELLS);
        rdAddr = {cellY[TPL_H_LOG2-1:0], cellX[TPL_W_LOG2-1:0]};
    end

    // Template RAM: no reset so it maps onto block RAM. A read and a write to
    // the same cell on the same edge return the old contents.
    logic [PIX_W-1:0] tplRam [DEPTH];
    logic [PIX_W-1:0] rdData;

    always_ff @(posedge iCLK) begin
        if (iWR_EN) tplRam[iWR_ADDR] <= iWR_DATA;
        rdData <= tplRam[rdAddr];
    end

    // Frame control
    always_comb begin
        stateNext = state;
        accClear  = 1'b0;
        oBUSY     = (state == ACCUM) || (state == DRAIN);
        // Starts are honoured in every state except DRAIN, and a start
        // tags the pixel arriving with it.
        tag0      = (state == ACCUM) || (iFRAME_START && (state != DRAIN));
        case (state)
            IDLE: begin
                if (iFRAME_START) begin
                    stateNext = ACCUM;
                    accClear  = 1'b1;
                end
            end
            ACCUM: begin
                if (iFRAME_START) begin
                    accClear = 1'b1;
                end else if (iFRAME_END) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt == 2'd2) stateNext = REPORT;
            end
            REPORT: begin
                if (iFRAME_START) begin
                    stateNext = ACCUM;
                    accClear  = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state    <= IDLE;
            drainCnt <= '0;
        end else begin
            state    <= stateNext;
            drainCnt <= (state == DRAIN) ? drainCnt + 2'd1 : '0;
        end
    end

    // Pixel pipeline: stage 1 waits for the RAM, stage 2 selects the value,
    // stage 3 drives the outputs, the SAD update uses stage 3.
    logic             v1, w1, t1, v2, w2, t2, t3;
    logic [PIX_W-1:0] p1, p2, p3, val2;
    logic [SCORE_W-1:0] acc;
    logic [PIX_W-1:0]   absDiff;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        absDiff = (p3 >= oVAL) ? (p3 - oVAL) : (oVAL - p3);
        sum     = SUM_W'(acc) + SUM_W'(absDiff);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            v1           <= 1'b0;
            w1           <= 1'b0;
            t1           <= 1'b0;
            p1           <= '0;
            v2           <= 1'b0;
            w2           <= 1'b0;
            t2           <= 1'b0;
            p2           <= '0;
            val2         <= '0;
            t3           <= 1'b0;
            p3           <= '0;
            oVAL         <= '0;
            oVAL_VALID   <= 1'b0;
            oIN_WIN      <= 1'b0;
            acc          <= '0;
            oSCORE       <= '0;
            oSCORE_VALID <= 1'b0;
            oMATCH       <= 1'b0;
        end else begin
            v1         <= iDVAL;
            w1         <= inWin0;
            t1         <= tag0 && inWin0;
            p1         <= iPIX;
            v2         <= v1;
            w2         <= w1;
            p2         <= p1;
            val2       <= w1 ? rdData : '0;
            p3         <= p2;
            oVAL       <= val2;
            oVAL_VALID <= v2;
            oIN_WIN    <= w2;
            // A restart drops the tags of pixels still in flight; the pixel
            // arriving with the start keeps its own tag via t1.
            t2 <= accClear ? 1'b0 : t1;
            t3 <= accClear ? 1'b0 : t2;

            if (accClear) begin
                acc <= '0;
            end else if (t3) begin
                acc <= (sum > ACC_MAX) ? ACC_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
            end

            oSCORE_VALID <= (state == REPORT);
            if (state == REPORT) begin
                oSCORE <= acc;
                oMATCH <= (acc <= iTHRESH);
            end
        end
    end

endmodule

// File: tb/tb_img_template_match.sv
// tb_img_template_match
//   Drives two matcher instances from one stimulus stream: the default
//   configuration and one with X0=32, SCORE_W=8. A frame-level reference
//   model predicts template values, window hits, SAD reports and busy.
module tb_img_template_match;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, dval, fs, fe, wrEn;
    logic [12:0] x, y;
    logic [9:0]  pix, wrData;
    logic [23:0] thresh;
    logic [7:0]  wrAddr;

    logic [9:0]  valA, valB;
    logic        valValidA, valValidB, inWinA, inWinB;
    logic [23:0] scoreA;
    logic [7:0]  scoreB;
    logic        scoreValidA, scoreValidB, matchA, matchB, busyA, busyB;

    img_template_match dutA (
        .iCLK(clk), .iRST_N(rstN), .iDVAL(dval), .iX(x), .iY(y), .iPIX(pix),
        .iFRAME_START(fs), .iFRAME_END(fe), .iTHRESH(thresh),
        .iWR_EN(wrEn), .iWR_ADDR(wrAddr), .iWR_DATA(wrData),
        .oVAL(valA), .oVAL_VALID(valValidA), .oIN_WIN(inWinA),
        .oSCORE(scoreA), .oSCORE_VALID(scoreValidA), .oMATCH(matchA), .oBUSY(busyA)
    );

    img_template_match #(.X0(32), .SCORE_W(8)) dutB (
        .iCLK(clk), .iRST_N(rstN), .iDVAL(dval), .iX(x), .iY(y), .iPIX(pix),
        .iFRAME_START(fs), .iFRAME_END(fe), .iTHRESH(thresh[7:0]),
        .iWR_EN(wrEn), .iWR_ADDR(wrAddr), .iWR_DATA(wrData),
        .oVAL(valB), .oVAL_VALID(valValidB), .oIN_WIN(inWinB),
        .oSCORE(scoreB), .oSCORE_VALID(scoreValidB), .oMATCH(matchB), .oBUSY(busyB)
    );

    localparam int NCYC = 8192;

    int     n = 0;
    int     checks = 0;
    int     errors = 0;
    int     tpl [256];
    bit     expV [2][NCYC];
    bit     expW [2][NCYC];
    int     expVal [2][NCYC];
    longint sum [2];
    longint repSum [2];
    longint lastScore [2];
    bit     lastMatch [2];
    bit     inFrame = 0;
    int     endCyc = -100;
    int     repCyc = -1;
    int     x0s [2] = '{0, 32};
    longint satMax [2] = '{longint'(24'hFFFFFF), longint'(255)};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    // 16x16 pixel cells, 16x16 cell template, window origin (x0s[k], 0)
    function automatic bit inWindow(input int k, input int px, input int py);
        return (px >= x0s[k]) && (py >= 0) && ((px - x0s[k]) / 16 < 16) && (py / 16 < 16);
    endfunction

    function automatic int cellOf(input int k, input int px, input int py);
        return (py / 16) * 16 + (px - x0s[k]) / 16;
    endfunction

    task automatic modelEdge();
        bit startAcc, draining;
        if (!rstN) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = n - 2; i <= n; i++)
                    if (i >= 0) begin
                        expV[k][i] = 0; expW[k][i] = 0; expVal[k][i] = 0;
                    end
                sum[k] = 0; lastScore[k] = 0; lastMatch[k] = 0;
            end
            inFrame = 0; endCyc = -100; repCyc = -1;
        end else begin
            if (n == repCyc)
                for (int k = 0; k < 2; k++) begin
                    lastScore[k] = repSum[k];
                    lastMatch[k] = repSum[k] <= ((k == 0) ? longint'(thresh) : longint'(thresh % 256));
                end
            draining = (n >= endCyc + 1) && (n <= endCyc + 3);
            startAcc = fs && !draining;
            for (int k = 0; k < 2; k++) begin
                bit w;
                int tv;
                w  = dval && inWindow(k, int'(x), int'(y));
                tv = w ? tpl[cellOf(k, int'(x), int'(y))] : 0;
                expV[k][n] = dval; expW[k][n] = w; expVal[k][n] = tv;
                if (startAcc) sum[k] = 0;
                if (w && (inFrame || startAcc)) begin
                    int d;
                    d = int'(pix) - tv;
                    if (d < 0) d = -d;
                    sum[k] = sum[k] + d;
                    if (sum[k] > satMax[k]) sum[k] = satMax[k];
                end
            end
            if (startAcc) begin
                inFrame = 1;
            end else if (fe && inFrame) begin
                inFrame = 0; endCyc = n; repCyc = n + 4;
                repSum[0] = sum[0]; repSum[1] = sum[1];
            end
            if (wrEn) tpl[wrAddr] = int'(wrData);
        end
    endtask

    task automatic checkDut(input int k, input logic [9:0] v, input logic vv, input logic w,
                            input logic [23:0] sc, input logic scv, input logic m, input logic b);
        bit ev;
        ev = (n >= 2) ? expV[k][n-2] : 1'b0;
        chk($sformatf("valValid%0d", k), 64'(vv), 64'(ev));
        if (ev) begin
            chk($sformatf("inWin%0d", k), 64'(w), 64'(expW[k][n-2]));
            chk($sformatf("val%0d", k), 64'(v), 64'(expVal[k][n-2]));
        end
        chk($sformatf("scoreValid%0d", k), 64'(scv), 64'(n == repCyc));
        chk($sformatf("score%0d", k), 64'(sc), 64'(lastScore[k]));
        chk($sformatf("match%0d", k), 64'(m), 64'(lastMatch[k]));
        chk($sformatf("busy%0d", k), 64'(b), 64'(inFrame || (n >= endCyc && n <= endCyc + 2)));
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (n >= NCYC) begin
            $display("FAIL cycleBudget cyc=%0d observed=over expected=under %0d", n, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
        modelEdge();
        #1;
        checkDut(0, valA, valValidA, inWinA, scoreA, scoreValidA, matchA, busyA);
        checkDut(1, valB, valValidB, inWinB, 24'(scoreB), scoreValidB, matchB, busyB);
    endtask

    task automatic idle(input int cnt);
        dval = 0; fs = 0; fe = 0; wrEn = 0;
        repeat (cnt) tick();
    endtask

    task automatic drive(input bit v, input int px, input int py, input int p, input bit s, input bit e);
        dval = v; x = 13'(px); y = 13'(py); pix = 10'(p); fs = s; fe = e;
        tick();
        dval = 0; fs = 0; fe = 0; wrEn = 0;
    endtask

    initial begin
        rstN = 0; dval = 0; fs = 0; fe = 0; wrEn = 0;
        x = '0; y = '0; pix = '0; thresh = '0; wrAddr = '0; wrData = '0;
        idle(2);
        rstN = 1;
        idle(1);

        // Template: all 255, cell 75 = 0
        for (int i = 0; i < 256; i++) begin
            wrEn = 1; wrAddr = 8'(i); wrData = (i == 75) ? 10'd0 : 10'd255;
            tick();
        end
        idle(1);

        // Window mapping and out-of-window cases
        drive(1, 176, 64, 123, 0, 0);
        drive(1, 175, 64, 321, 0, 0);
        drive(1, 256, 0, 9, 0, 0);
        drive(1, 31, 0, 9, 0, 0);
        drive(0, 40, 40, 9, 0, 0);
        idle(3);
        repeat (40) drive($urandom_range(0, 1), $urandom_range(0, 300), $urandom_range(0, 300),
                          $urandom_range(0, 1023), 0, 0);
        wrEn = 1; wrAddr = 8'd75; wrData = 10'd255;
        idle(3);

        // SAD report, match and no-match
        thresh = 24'd500;
        drive(1, 40, 10, 100, 1, 0);
        drive(1, 50, 10, 100, 0, 0);
        drive(1, 60, 10, 100, 0, 1);
        idle(6);
        thresh = 24'd464;
        drive(1, 40, 10, 100, 1, 0);
        drive(1, 50, 10, 100, 0, 0);
        drive(1, 60, 10, 100, 0, 1);
        idle(6);

        // Saturation on the 8-bit accumulator
        drive(1, 40, 10, 0, 1, 0);
        drive(1, 50, 10, 0, 0, 1);
        idle(6);

        // Write and read of cell 5 on the same edge
        wrEn = 1; wrAddr = 8'd5; wrData = 10'd7;
        drive(1, 80, 0, 1, 0, 0);
        drive(1, 80, 0, 1, 0, 0);
        idle(3);

        // Restart with start and end in the same cycle
        thresh = 24'd1000;
        drive(1, 40, 20, 500, 1, 0);
        drive(1, 41, 20, 600, 0, 0);
        drive(1, 42, 20, 77, 1, 1);
        drive(1, 43, 20, 300, 0, 0);
        drive(1, 44, 20, 3, 0, 1);
        idle(6);

        // Randomized frames, one of them restarting in the report cycle
        for (int f = 0; f < 4; f++) begin
            thresh = 24'($urandom_range(0, 20000));
            drive($urandom_range(0, 1), $urandom_range(0, 300), $urandom_range(0, 300),
                  $urandom_range(0, 1023), 1, 0);
            repeat (25) begin
                if ($urandom_range(0, 3) == 0) begin
                    wrEn = 1; wrAddr = 8'($urandom_range(0, 255)); wrData = 10'($urandom_range(0, 1023));
                end
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 300), $urandom_range(0, 300),
                      $urandom_range(0, 1023), $urandom_range(0, 15) == 0, 0);
            end
            drive(1, $urandom_range(32, 255), $urandom_range(0, 255), $urandom_range(0, 1023), 0, 1);
            idle((f == 1) ? 3 : 5);
        end
        idle(3);

        // Reset during a frame: the later end produces nothing
        drive(1, 40, 10, 0, 1, 0);
        drive(1, 50, 10, 0, 0, 0);
        rstN = 0;
        idle(1);
        rstN = 1;
        drive(1, 60, 10, 5, 0, 1);
        idle(6);

        // End while idle is ignored
        drive(0, 0, 0, 0, 0, 1);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
